// File: rtl/axi4lite_sram_model.sv
// rtl/axi4lite_sram_model.sv - AXI4-Lite slave SRAM model with read latency, range errors and tohost mailbox
// Optional ready stalling via AXI_SRAM_STALL_EN.
module axi4lite_sram_model #(
    parameter int          ADDR_WIDTH   = 32,
    parameter int          DEPTH_WORDS  = 16384,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] TOHOST_ADDR  = 32'h0000_6000,
    parameter logic [31:0] SUCCESS_CODE = 32'h1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [2:0]            awprot,
    input  logic [3:0]            awcache,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [2:0]            arprot,
    input  logic [3:0]            arcache,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [1:0]            rresp,
    output logic [31:0]           rdata,
    output logic                  tohost_valid,
    output logic                  tohost_pass,
    output logic [31:0]           tohost_code
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] TOHOST_IDX = TOHOST_ADDR[IDX_W+1:2];
    localparam bit TOHOST_OK = (TOHOST_ADDR >> (IDX_W + 2)) == 32'd0;
    localparam int WAIT_INIT = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    logic [31:0] mem [DEPTH_WORDS];

    w_state_t       w_state;
    r_state_t       r_state;
    logic           awready_r, wready_r, arready_r, stall;
    logic           aw_held, w_held, aw_ok_q;
    logic [IDX_W-1:0] aw_idx_q;
    logic [31:0]    wdata_q;
    logic [3:0]     wstrb_q;
    logic [2:0]     rcnt;
    logic           unused_ok;

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a >> (IDX_W + 2)) == '0;
    endfunction

`ifdef AXI_SRAM_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge aclk) begin
        if (!aresetn) lfsr <= 16'hACE1;
        else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    assign awready   = awready_r & ~stall;
    assign wready    = wready_r & ~stall;
    assign arready   = arready_r & ~stall;
    assign unused_ok = ^{awprot, awcache, arprot, arcache, awaddr[1:0], araddr[1:0]};

    logic             aw_fire, w_fire, commit, cur_ok;
    logic [IDX_W-1:0] cur_idx;
    logic [31:0]      cur_data;
    logic [3:0]       cur_strb;

    // Held AW/W values take priority; otherwise use the beat handshaking this cycle.
    always_comb begin
        aw_fire  = awvalid & awready;
        w_fire   = wvalid & wready;
        cur_idx  = aw_held ? aw_idx_q : awaddr[IDX_W+1:2];
        cur_ok   = aw_held ? aw_ok_q : addr_ok(awaddr);
        cur_data = w_held ? wdata_q : wdata;
        cur_strb = w_held ? wstrb_q : wstrb;
        commit   = (w_state == W_IDLE) & (aw_held | aw_fire) & (w_held | w_fire);
    end

    always_ff @(posedge aclk) begin
        if (aresetn && commit && cur_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_strb[b]) mem[cur_idx][8*b +: 8] <= cur_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state      <= W_IDLE;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_ok_q      <= 1'b0;
            aw_idx_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awready_r    <= 1'b1;
            wready_r     <= 1'b1;
            bvalid       <= 1'b0;
            bresp        <= RESP_OKAY;
            tohost_valid <= 1'b0;
            tohost_pass  <= 1'b0;
            tohost_code  <= '0;
        end else begin
            tohost_valid <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    if (aw_fire) begin
                        aw_held   <= 1'b1;
                        aw_idx_q  <= awaddr[IDX_W+1:2];
                        aw_ok_q   <= addr_ok(awaddr);
                        awready_r <= 1'b0;
                    end
                    if (w_fire) begin
                        w_held   <= 1'b1;
                        wdata_q  <= wdata;
                        wstrb_q  <= wstrb;
                        wready_r <= 1'b0;
                    end
                    if (commit) begin
                        w_state   <= W_RESP;
                        bvalid    <= 1'b1;
                        bresp     <= cur_ok ? RESP_OKAY : RESP_SLVERR;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b0;
                        if (cur_ok && TOHOST_OK && cur_idx == TOHOST_IDX) begin
                            tohost_valid <= 1'b1;
                            tohost_code  <= cur_data;
                            tohost_pass  <= (cur_data == SUCCESS_CODE);
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        w_state   <= W_IDLE;
                        bvalid    <= 1'b0;
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                        awready_r <= 1'b1;
                        wready_r  <= 1'b1;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read data is sampled at the AR handshake; the wait state only delays presentation.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state   <= R_IDLE;
            arready_r <= 1'b1;
            rvalid    <= 1'b0;
            rresp     <= RESP_OKAY;
            rdata     <= '0;
            rcnt      <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        arready_r <= 1'b0;
                        rdata     <= addr_ok(araddr) ? mem[araddr[IDX_W+1:2]] : 32'd0;
                        rresp     <= addr_ok(araddr) ? RESP_OKAY : RESP_SLVERR;
                        rcnt      <= 3'(WAIT_INIT);
                        if (READ_LATENCY == 1) begin
                            r_state <= R_RESP;
                            rvalid  <= 1'b1;
                        end else begin
                            r_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (rcnt == 3'd0) begin
                        r_state <= R_RESP;
                        rvalid  <= 1'b1;
                    end else begin
                        rcnt <= rcnt - 3'd1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        r_state   <= R_IDLE;
                        rvalid    <= 1'b0;
                        arready_r <= 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule
